axi_cache_bridge: RTL and testbench

Parametrised successor bridge between the CPU's cache-side interfaces and a single AXI3 master port. It serves icache line/uncached reads, dcache line/uncached reads, and dcache line writebacks or uncached writes, with full AXI bursts in both directions. One read may be outstanding per source at the same time, plus one write. Reads that hit a pending write line are held off. It sits between icache/dcache and the SoC AXI crossbar, replacing the single-beat-write bridge.

---
 rtl/axi_cache_bridge_pkg.sv | 42 ++++
 rtl/axi_bridge_wchan.sv | 137 +++++++++++++
 rtl/axi_cache_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_axi_cache_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_cache_bridge_pkg.sv
// Shared AXI3 field widths, cache request encodings and FSM states for the cache-to-AXI bridge.
package axi_cache_bridge_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned LOCK_W  = 2;
    localparam int unsigned CACHE_W = 4;
    localparam int unsigned PROT_W  = 3;
    localparam int unsigned RESP_W  = 2;
    localparam int unsigned TYPE_W  = 3;

    localparam int unsigned IC_ID = 0;
    localparam int unsigned DC_ID = 1;

    localparam logic [TYPE_W-1:0] TYPE_BYTE = 3'b000;
    localparam logic [TYPE_W-1:0] TYPE_HALF = 3'b001;
    localparam logic [TYPE_W-1:0] TYPE_WORD = 3'b010;
    localparam logic [TYPE_W-1:0] TYPE_LINE = 3'b100;

    localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;
    localparam logic [SIZE_W-1:0]  SIZE_WORD  = 3'd2;

    typedef enum logic {AR_IDLE, AR_REQ} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    // Address/len/size payload shared by AR and AW
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
    } ax_req_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a,
                                                     input int unsigned off_w);
        return a & ~((32'd1 << off_w) - 32'd1);
    endfunction

endpackage

// File: rtl/axi_bridge_wchan.sv
// Write side of the bridge: captures one dcache write (line or uncached) and drives AW/W/B.
module axi_bridge_wchan
    import axi_cache_bridge_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         dc_wr_req,
    input  logic [TYPE_W-1:0]            dc_wr_type,
    input  logic [ADDR_W-1:0]            dc_wr_addr,
    input  logic [STRB_W-1:0]            dc_wr_wstrb,
    input  logic [LINE_WORDS*DATA_W-1:0] dc_wr_data,
    output logic                         dc_wr_rdy,
    output logic [ADDR_W-1:0]            awaddr,
    output logic [LEN_W-1:0]             awlen,
    output logic [SIZE_W-1:0]            awsize,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [DATA_W-1:0]            wdata,
    output logic [STRB_W-1:0]            wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic                         bvalid,
    output logic                         bready,
    output logic                         pend_c,
    output logic [ADDR_W-1:0]            pend_line_c
);

    localparam int unsigned CNT_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W = $clog2(LINE_WORDS) + 2;

    w_state_t            state_q, state_d;
    ax_req_t             aw_q, aw_next_c;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                wlast_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   line_q [LINE_WORDS];
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nxt_c;
    logic                acc_c, w_hs_c, is_line_c;

    assign acc_c     = dc_wr_req && (state_q == W_IDLE);
    assign w_hs_c    = wvalid_q && wready;
    assign cnt_nxt_c = CNT_W'(cnt_q + 1'b1);
    assign is_line_c = (dc_wr_type == TYPE_LINE);

    always_comb begin
        aw_next_c.addr = dc_wr_addr;
        aw_next_c.len  = is_line_c ? LEN_W'(LINE_WORDS - 1) : '0;
        aw_next_c.size = is_line_c ? SIZE_WORD : {1'b0, dc_wr_type[1:0]};
    end

    // Next state: AW and W complete independently, B is awaited once both are done
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        cnt_d     = cnt_q;
        case (state_q)
            W_IDLE: begin
                if (dc_wr_req) begin
                    state_d   = W_SEND;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    cnt_d     = '0;
                end
            end
            W_SEND: begin
                if (awready) awvalid_d = 1'b0;
                if (w_hs_c) begin
                    if (wlast_q) wvalid_d = 1'b0;
                    else         cnt_d    = cnt_nxt_c;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = W_RESP;
                    bready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    state_d  = W_IDLE;
                    bready_d = 1'b0;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            cnt_q     <= '0;
            aw_q      <= '0;
            wlast_q   <= 1'b0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            for (int i = 0; i < int'(LINE_WORDS); i++) line_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            cnt_q     <= cnt_d;
            if (acc_c) begin
                aw_q    <= aw_next_c;
                wlast_q <= !is_line_c;
                wstrb_q <= is_line_c ? {STRB_W{1'b1}} : dc_wr_wstrb;
                wdata_q <= dc_wr_data[DATA_W-1:0];
                for (int i = 0; i < int'(LINE_WORDS); i++)
                    line_q[i] <= dc_wr_data[i*DATA_W +: DATA_W];
            end else if (state_q == W_SEND && w_hs_c && !wlast_q) begin
                wdata_q <= line_q[cnt_nxt_c];
                wlast_q <= (LEN_W'(cnt_nxt_c) == aw_q.len);
            end
        end
    end

    assign dc_wr_rdy   = (state_q == W_IDLE);
    assign awaddr      = aw_q.addr;
    assign awlen       = aw_q.len;
    assign awsize      = aw_q.size;
    assign awvalid     = awvalid_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign wlast       = wlast_q;
    assign wvalid      = wvalid_q;
    assign bready      = bready_q;
    assign pend_c      = (state_q != W_IDLE);
    assign pend_line_c = line_align(aw_q.addr, OFF_W);

endmodule

// File: rtl/axi_cache_bridge.sv
// icache/dcache to AXI3 master bridge: one read per source plus one write in flight.
// Define AXI_BRIDGE_RAW_CHECK_EN to hold off reads that hit the pending write line.
module axi_cache_bridge
    import axi_cache_bridge_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ID_W       = 4
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         ic_rd_req,
    input  logic [TYPE_W-1:0]            ic_rd_type,
    input  logic [ADDR_W-1:0]            ic_rd_addr,
    output logic                         ic_rd_rdy,
    output logic                         ic_ret_valid,
    output logic                         ic_ret_last,
    output logic [DATA_W-1:0]            ic_ret_data,
    input  logic                         dc_rd_req,
    input  logic [TYPE_W-1:0]            dc_rd_type,
    input  logic [ADDR_W-1:0]            dc_rd_addr,
    output logic                         dc_rd_rdy,
    output logic                         dc_ret_valid,
    output logic                         dc_ret_last,
    output logic [DATA_W-1:0]            dc_ret_data,
    input  logic                         dc_wr_req,
    input  logic [TYPE_W-1:0]            dc_wr_type,
    input  logic [ADDR_W-1:0]            dc_wr_addr,
    input  logic [STRB_W-1:0]            dc_wr_wstrb,
    input  logic [LINE_WORDS*DATA_W-1:0] dc_wr_data,
    output logic                         dc_wr_rdy,
    output logic [ID_W-1:0]              arid,
    output logic [ADDR_W-1:0]            araddr,
    output logic [LEN_W-1:0]             arlen,
    output logic [SIZE_W-1:0]            arsize,
    output logic [BURST_W-1:0]           arburst,
    output logic [LOCK_W-1:0]            arlock,
    output logic [CACHE_W-1:0]           arcache,
    output logic [PROT_W-1:0]            arprot,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [ID_W-1:0]              rid,
    input  logic [DATA_W-1:0]            rdata,
    input  logic [RESP_W-1:0]            rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready,
    output logic [ID_W-1:0]              awid,
    output logic [ADDR_W-1:0]            awaddr,
    output logic [LEN_W-1:0]             awlen,
    output logic [SIZE_W-1:0]            awsize,
    output logic [BURST_W-1:0]           awburst,
    output logic [LOCK_W-1:0]            awlock,
    output logic [CACHE_W-1:0]           awcache,
    output logic [PROT_W-1:0]            awprot,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [ID_W-1:0]              wid,
    output logic [DATA_W-1:0]            wdata,
    output logic [STRB_W-1:0]            wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic [ID_W-1:0]              bid,
    input  logic [RESP_W-1:0]            bresp,
    input  logic                         bvalid,
    output logic                         bready
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS) + 2;

    ar_state_t         ar_state_q, ar_state_d;
    ax_req_t           ar_q, ar_next_c;
    logic [ID_W-1:0]   arid_q;
    logic              arvalid_q, ic_out_q, dc_out_q, rready_q;
    logic              ic_ret_valid_q, ic_ret_last_q, dc_ret_valid_q, dc_ret_last_q;
    logic [DATA_W-1:0] ic_ret_data_q, dc_ret_data_q;
    logic              ar_idle_c, ic_acc_c, dc_acc_c, r_hs_c, ar_hs_c;
    logic              hazard_ic_c, hazard_dc_c, wr_pend_c;
    logic [ADDR_W-1:0] wr_line_c, rd_addr_c;
    logic [TYPE_W-1:0] rd_type_c;
    logic              unused_c;

`ifdef AXI_BRIDGE_RAW_CHECK_EN
    logic              wr_acc_c;
    logic [ADDR_W-1:0] wr_in_line_c;
    // A write accepted this cycle is already pending from the read's point of view
    assign wr_acc_c     = dc_wr_req && dc_wr_rdy;
    assign wr_in_line_c = line_align(dc_wr_addr, OFF_W);
    assign hazard_ic_c  = (wr_pend_c && line_align(ic_rd_addr, OFF_W) == wr_line_c) ||
                          (wr_acc_c  && line_align(ic_rd_addr, OFF_W) == wr_in_line_c);
    assign hazard_dc_c  = (wr_pend_c && line_align(dc_rd_addr, OFF_W) == wr_line_c) ||
                          (wr_acc_c  && line_align(dc_rd_addr, OFF_W) == wr_in_line_c);
`else
    logic unused_hazard_c;
    assign hazard_ic_c     = 1'b0;
    assign hazard_dc_c     = 1'b0;
    assign unused_hazard_c = ^{wr_pend_c, wr_line_c};
`endif

    // dcache has priority; icache also yields whenever dcache is requesting
    assign ar_idle_c = (ar_state_q == AR_IDLE);
    assign dc_rd_rdy = ar_idle_c && !dc_out_q && !hazard_dc_c;
    assign ic_rd_rdy = ar_idle_c && !ic_out_q && !dc_rd_req && !hazard_ic_c;
    assign dc_acc_c  = dc_rd_req && dc_rd_rdy;
    assign ic_acc_c  = ic_rd_req && ic_rd_rdy;
    assign ar_hs_c   = arvalid_q && arready;
    assign r_hs_c    = rvalid && rready_q;
    assign rd_type_c = dc_acc_c ? dc_rd_type : ic_rd_type;
    assign rd_addr_c = dc_acc_c ? dc_rd_addr : ic_rd_addr;

    always_comb begin
        ar_next_c.addr = rd_addr_c;
        ar_next_c.len  = '0;
        ar_next_c.size = {1'b0, rd_type_c[1:0]};
        if (rd_type_c == TYPE_LINE) begin
            ar_next_c.addr = line_align(rd_addr_c, OFF_W);
            ar_next_c.len  = LEN_W'(LINE_WORDS - 1);
            ar_next_c.size = SIZE_WORD;
        end
    end

    always_comb begin
        ar_state_d = ar_state_q;
        case (ar_state_q)
            AR_IDLE: if (ic_acc_c || dc_acc_c) ar_state_d = AR_REQ;
            AR_REQ:  if (arready)              ar_state_d = AR_IDLE;
            default:                           ar_state_d = AR_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ar_state_q     <= AR_IDLE;
            arvalid_q      <= 1'b0;
            ar_q           <= '0;
            arid_q         <= '0;
            ic_out_q       <= 1'b0;
            dc_out_q       <= 1'b0;
            rready_q       <= 1'b0;
            ic_ret_valid_q <= 1'b0;
            ic_ret_last_q  <= 1'b0;
            ic_ret_data_q  <= '0;
            dc_ret_valid_q <= 1'b0;
            dc_ret_last_q  <= 1'b0;
            dc_ret_data_q  <= '0;
        end else begin
            ar_state_q <= ar_state_d;
            arvalid_q  <= (ar_state_d == AR_REQ);
            rready_q   <= 1'b1;
            if (ic_acc_c || dc_acc_c) begin
                ar_q   <= ar_next_c;
                arid_q <= dc_acc_c ? ID_W'(DC_ID) : ID_W'(IC_ID);
            end
            // Outstanding flags: a burst ends on its own rlast
            if (r_hs_c && rlast && !rid[0]) ic_out_q <= 1'b0;
            if (r_hs_c && rlast &&  rid[0]) dc_out_q <= 1'b0;
            if (ar_hs_c && !arid_q[0])      ic_out_q <= 1'b1;
            if (ar_hs_c &&  arid_q[0])      dc_out_q <= 1'b1;
            ic_ret_valid_q <= r_hs_c && !rid[0];
            ic_ret_last_q  <= r_hs_c && !rid[0] && rlast;
            dc_ret_valid_q <= r_hs_c &&  rid[0];
            dc_ret_last_q  <= r_hs_c &&  rid[0] && rlast;
            if (r_hs_c && !rid[0]) ic_ret_data_q <= rdata;
            if (r_hs_c &&  rid[0]) dc_ret_data_q <= rdata;
        end
    end

    axi_bridge_wchan #(
        .LINE_WORDS (LINE_WORDS)
    ) u_wchan (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .dc_wr_req   (dc_wr_req),
        .dc_wr_type  (dc_wr_type),
        .dc_wr_addr  (dc_wr_addr),
        .dc_wr_wstrb (dc_wr_wstrb),
        .dc_wr_data  (dc_wr_data),
        .dc_wr_rdy   (dc_wr_rdy),
        .awaddr      (awaddr),
        .awlen       (awlen),
        .awsize      (awsize),
        .awvalid     (awvalid),
        .awready     (awready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wlast       (wlast),
        .wvalid      (wvalid),
        .wready      (wready),
        .bvalid      (bvalid),
        .bready      (bready),
        .pend_c      (wr_pend_c),
        .pend_line_c (wr_line_c)
    );

    assign arid         = arid_q;
    assign araddr       = ar_q.addr;
    assign arlen        = ar_q.len;
    assign arsize       = ar_q.size;
    assign arburst      = BURST_INCR;
    assign arlock       = '0;
    assign arcache      = '0;
    assign arprot       = '0;
    assign arvalid      = arvalid_q;
    assign rready       = rready_q;
    assign ic_ret_valid = ic_ret_valid_q;
    assign ic_ret_last  = ic_ret_last_q;
    assign ic_ret_data  = ic_ret_data_q;
    assign dc_ret_valid = dc_ret_valid_q;
    assign dc_ret_last  = dc_ret_last_q;
    assign dc_ret_data  = dc_ret_data_q;
    assign awid         = ID_W'(DC_ID);
    assign awburst      = BURST_INCR;
    assign awlock       = '0;
    assign awcache      = '0;
    assign awprot       = '0;
    assign wid          = ID_W'(DC_ID);
    assign unused_c     = ^{rresp, bid, bresp, rid[ID_W-1:1]};

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Directed bench for axi_cache_bridge with the bench acting as the AXI slave.
module tb_axi_cache_bridge;

    localparam int unsigned LW   = 4;
    localparam int unsigned ID_W = 4;

    logic aclk, aresetn;
    logic ic_rd_req, ic_rd_rdy, ic_ret_valid, ic_ret_last;
    logic [2:0] ic_rd_type;
    logic [31:0] ic_rd_addr, ic_ret_data;
    logic dc_rd_req, dc_rd_rdy, dc_ret_valid, dc_ret_last;
    logic [2:0] dc_rd_type;
    logic [31:0] dc_rd_addr, dc_ret_data;
    logic dc_wr_req, dc_wr_rdy;
    logic [2:0] dc_wr_type;
    logic [31:0] dc_wr_addr;
    logic [3:0] dc_wr_wstrb;
    logic [LW*32-1:0] dc_wr_data;
    logic [ID_W-1:0] arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, arprot, awsize, awprot;
    logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
    logic [3:0] arcache, awcache, wstrb;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int failures = 0;

    axi_cache_bridge #(.LINE_WORDS(LW), .ID_W(ID_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
        .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
        .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
        .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
        .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next active edge; outputs are sampled 1ns after it
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        aresetn = 1'b0;
        ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
        dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
        dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = '0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        // Reset values
        tick(); tick();
        chk("rst_arvalid", 64'(arvalid), 0);
        chk("rst_awvalid", 64'(awvalid), 0);
        chk("rst_wvalid", 64'(wvalid), 0);
        chk("rst_bready", 64'(bready), 0);
        chk("rst_rready", 64'(rready), 0);
        chk("rst_ic_ret_valid", 64'(ic_ret_valid), 0);
        chk("rst_araddr", 64'(araddr), 0);
        aresetn = 1'b1;
        tick();
        chk("rready_after_rst", 64'(rready), 1);

        // Uncached icache byte read
        ic_rd_req = 1; ic_rd_type = 3'b000; ic_rd_addr = 32'h1C00_0013;
        settle();
        chk("byte_ic_rdy", 64'(ic_rd_rdy), 1);
        tick();
        ic_rd_req = 0;
        settle();
        chk("byte_arvalid", 64'(arvalid), 1);
        chk("byte_araddr", 64'(araddr), 64'h1C00_0013);
        chk("byte_arlen", 64'(arlen), 0);
        chk("byte_arsize", 64'(arsize), 0);
        chk("byte_arid", 64'(arid), 0);
        tick();
        chk("byte_arvalid_hold", 64'(arvalid), 1);
        arready = 1;
        tick();
        arready = 0;
        settle();
        chk("byte_arvalid_drop", 64'(arvalid), 0);
        chk("byte_ic_rdy_outstanding", 64'(ic_rd_rdy), 0);
        rvalid = 1; rid = 0; rdata = 32'h0000_0055; rlast = 1;
        tick();
        rvalid = 0; rlast = 0;
        chk("byte_ret_valid", 64'(ic_ret_valid), 1);
        chk("byte_ret_data", 64'(ic_ret_data), 64'h55);
        chk("byte_ret_last", 64'(ic_ret_last), 1);
        tick();
        chk("byte_ret_pulse", 64'(ic_ret_valid), 0);
        chk("byte_ic_rdy_free", 64'(ic_rd_rdy), 1);

        // icache line read: aligned burst of 4 words
        ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0010;
        tick();
        ic_rd_req = 0;
        chk("line_araddr", 64'(araddr), 64'h1C00_0010);
        chk("line_arlen", 64'(arlen), 3);
        chk("line_arsize", 64'(arsize), 2);
        chk("line_arburst", 64'(arburst), 1);
        arready = 1;
        tick();
        arready = 0;
        for (int i = 0; i < 4; i++) begin
            rvalid = 1; rid = 0; rdata = 32'h1000 + 32'(i); rlast = (i == 3);
            tick();
            rvalid = 0; rlast = 0;
            chk("line_ret_valid", 64'(ic_ret_valid), 1);
            chk("line_ret_data", 64'(ic_ret_data), 64'h1000 + 64'(i));
            chk("line_ret_last", 64'(ic_ret_last), (i == 3) ? 64'd1 : 64'd0);
            chk("line_dc_quiet", 64'(dc_ret_valid), 0);
            tick();
            chk("line_ret_gap", 64'(ic_ret_valid), 0);
        end

        // Same-cycle ic/dc requests: dcache wins, icache follows the AR handshake
        ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h0000_2008;
        dc_rd_req = 1; dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_3004;
        settle();
        chk("prio_dc_rdy", 64'(dc_rd_rdy), 1);
        chk("prio_ic_rdy", 64'(ic_rd_rdy), 0);
        tick();
        dc_rd_req = 0;
        settle();
        chk("prio_arid_dc", 64'(arid), 1);
        chk("prio_araddr_dc", 64'(araddr), 64'h0000_3000);
        chk("prio_ic_wait", 64'(ic_rd_rdy), 0);
        arready = 1;
        tick();
        arready = 0;
        settle();
        chk("prio_ic_rdy_after", 64'(ic_rd_rdy), 1);
        tick();
        ic_rd_req = 0;
        chk("prio_arid_ic", 64'(arid), 0);
        chk("prio_araddr_ic", 64'(araddr), 64'h0000_2000);
        arready = 1;
        tick();
        arready = 0;

        // Interleaved R beats, dcache first, alternating ids
        for (int i = 0; i < 8; i++) begin
            logic is_dc;
            int   beat;
            is_dc = (i % 2 == 0);
            beat  = i / 2;
            rvalid = 1; rid = is_dc ? 4'd1 : 4'd0;
            rdata = (is_dc ? 32'hD000 : 32'hC000) + 32'(beat); rlast = (beat == 3);
            tick();
            if (is_dc) begin
                chk("ilv_dc_valid", 64'(dc_ret_valid), 1);
                chk("ilv_dc_data", 64'(dc_ret_data), 64'hD000 + 64'(beat));
                chk("ilv_dc_last", 64'(dc_ret_last), (beat == 3) ? 64'd1 : 64'd0);
                chk("ilv_ic_quiet", 64'(ic_ret_valid), 0);
            end else begin
                chk("ilv_ic_valid", 64'(ic_ret_valid), 1);
                chk("ilv_ic_data", 64'(ic_ret_data), 64'hC000 + 64'(beat));
                chk("ilv_ic_last", 64'(ic_ret_last), (beat == 3) ? 64'd1 : 64'd0);
                chk("ilv_dc_quiet", 64'(dc_ret_valid), 0);
            end
        end
        rvalid = 0; rlast = 0;
        tick();
        chk("ilv_end_ic", 64'(ic_ret_valid), 0);
        chk("ilv_end_dc", 64'(dc_ret_valid), 0);

        // dcache line write with a two-cycle W stall on beat 1
        dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h8000_1000; dc_wr_wstrb = 4'h0;
        dc_wr_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        settle();
        chk("wr_rdy_idle", 64'(dc_wr_rdy), 1);
        tick();
        dc_wr_req = 0;
        chk("wr_awvalid", 64'(awvalid), 1);
        chk("wr_wvalid", 64'(wvalid), 1);
        chk("wr_awaddr", 64'(awaddr), 64'h8000_1000);
        chk("wr_awlen", 64'(awlen), 3);
        chk("wr_awsize", 64'(awsize), 2);
        chk("wr_wstrb", 64'(wstrb), 64'hF);
        chk("wr_awid", 64'(awid), 1);
        chk("wr_d0", 64'(wdata), 64'hA0);
        chk("wr_last0", 64'(wlast), 0);
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        chk("wr_aw_done", 64'(awvalid), 0);
        chk("wr_d1", 64'(wdata), 64'hA1);
        tick();
        chk("wr_d1_stall1", 64'(wdata), 64'hA1);
        tick();
        chk("wr_d1_stall2", 64'(wdata), 64'hA1);
        chk("wr_rdy_busy", 64'(dc_wr_rdy), 0);
        wready = 1;
        tick();
        chk("wr_d2", 64'(wdata), 64'hA2);
        chk("wr_last2", 64'(wlast), 0);
        tick();
        chk("wr_d3", 64'(wdata), 64'hA3);
        chk("wr_last3", 64'(wlast), 1);
        tick();
        wready = 0;
        chk("wr_wvalid_done", 64'(wvalid), 0);
        chk("wr_bready", 64'(bready), 1);
        chk("wr_rdy_wait_b", 64'(dc_wr_rdy), 0);

        // Read into the pending write line
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h8000_1008;
        settle();
`ifdef AXI_BRIDGE_RAW_CHECK_EN
        chk("raw_blocked", 64'(dc_rd_rdy), 0);
        tick();
        chk("raw_no_ar", 64'(arvalid), 0);
        chk("raw_still_blocked", 64'(dc_rd_rdy), 0);
        bvalid = 1;
        tick();
        bvalid = 0;
        chk("raw_wr_rdy_back", 64'(dc_wr_rdy), 1);
        chk("raw_released", 64'(dc_rd_rdy), 1);
        tick();
        dc_rd_req = 0;
`else
        chk("raw_free", 64'(dc_rd_rdy), 1);
        tick();
        dc_rd_req = 0;
        bvalid = 1;
        tick();
        bvalid = 0;
        chk("raw_wr_rdy_back", 64'(dc_wr_rdy), 1);
`endif
        chk("raw_arvalid", 64'(arvalid), 1);
        chk("raw_araddr", 64'(araddr), 64'h8000_1008);
        chk("raw_arid", 64'(arid), 1);
        chk("raw_arsize", 64'(arsize), 2);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rid = 1; rdata = 32'h77; rlast = 1;
        tick();
        rvalid = 0; rlast = 0;
        chk("raw_ret_valid", 64'(dc_ret_valid), 1);
        chk("raw_ret_data", 64'(dc_ret_data), 64'h77);

        // Uncached half-word write: fastest turnaround
        dc_wr_req = 1; dc_wr_type = 3'b001; dc_wr_addr = 32'h4000_0002; dc_wr_wstrb = 4'b1100;
        dc_wr_data = '0; dc_wr_data[31:0] = 32'h1234_5678;
        tick();
        dc_wr_req = 0;
        chk("sw_awlen", 64'(awlen), 0);
        chk("sw_awsize", 64'(awsize), 1);
        chk("sw_awaddr", 64'(awaddr), 64'h4000_0002);
        chk("sw_wstrb", 64'(wstrb), 64'hC);
        chk("sw_wlast", 64'(wlast), 1);
        chk("sw_wdata", 64'(wdata), 64'h1234_5678);
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        chk("sw_bready", 64'(bready), 1);
        chk("sw_awvalid_off", 64'(awvalid), 0);
        bvalid = 1;
        tick();
        bvalid = 0;
        chk("sw_rdy_back", 64'(dc_wr_rdy), 1);
        chk("sw_bready_off", 64'(bready), 0);

        // Reset in the middle of a line read
        ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0040;
        tick();
        ic_rd_req = 0;
        arready = 1;
        tick();
        arready = 0;
        for (int i = 0; i < 2; i++) begin
            rvalid = 1; rid = 0; rdata = 32'h2000 + 32'(i); rlast = 0;
            tick();
        end
        chk("mid_beat1", 64'(ic_ret_data), 64'h2001);
        rvalid = 1; rid = 0; rdata = 32'h2002; rlast = 0;
        aresetn = 0;
        tick();
        rvalid = 0;
        chk("mid_ret_valid", 64'(ic_ret_valid), 0);
        chk("mid_ret_data", 64'(ic_ret_data), 0);
        chk("mid_ret_last", 64'(ic_ret_last), 0);
        chk("mid_rready", 64'(rready), 0);
        chk("mid_arvalid", 64'(arvalid), 0);
        chk("mid_araddr", 64'(araddr), 0);
        chk("mid_arlen", 64'(arlen), 0);
        aresetn = 1;
        tick();
        settle();
        chk("mid_ic_rdy", 64'(ic_rd_rdy), 1);
        chk("mid_rready_back", 64'(rready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
